port_array_queue: RTL and testbench

// - Per-port val/rdy buffering stage that sits directly upstream of the

---
 rtl/port_array_queue.sv | 97 +++++++++
 tb/tb_port_array_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/port_array_queue.sv
// port_array_queue: a separate val/rdy FIFO for each port. It sits upstream
// of the flattened port-array pass-through, so a stalled consumer port never
// blocks the other ports.
//
// Optional feature: PORT_ARRAY_QUEUE_BYPASS_EN lets a word pass straight from
// an empty port's input to its output in the same cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous reset, active low
//   in_val   per-port enqueue valid
//   in_rdy   per-port enqueue ready
//   in_      enqueue data, port i at [i*nbits +: nbits]
//   out_val  per-port dequeue valid
//   out_rdy  per-port dequeue ready
//   out      head-entry data, same layout as in_
//   count    per-port occupancy, port i at [i*cw +: cw]
module port_array_queue #(
  parameter int unsigned nports   = 2,
  parameter int unsigned nbits    = 32,
  parameter int unsigned nentries = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [nports-1:0]                       in_val,
  output logic [nports-1:0]                       in_rdy,
  input  logic [nports*nbits-1:0]                 in_,
  output logic [nports-1:0]                       out_val,
  input  logic [nports-1:0]                       out_rdy,
  output logic [nports*nbits-1:0]                 out,
  output logic [nports*$clog2(nentries+1)-1:0]    count
);

  localparam int unsigned cw = $clog2(nentries + 1);
  localparam int unsigned pw = $clog2(nentries);

  for (genvar i = 0; i < nports; i++) begin : g_port
    logic [nbits-1:0] mem [nentries];
    logic [pw-1:0]    enq_ptr;
    logic [pw-1:0]    deq_ptr;
    logic [cw-1:0]    cnt;
    logic [nbits-1:0] din;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic             wr;

    assign din   = in_[i*nbits +: nbits];
    assign full  = (cnt == cw'(nentries));
    assign empty = (cnt == '0);

    // No enqueue while full, even if a dequeue happens in the same cycle.
    assign in_rdy[i] = reset & ~full;
    assign enq       = in_val[i] & in_rdy[i];
    // Dequeue from storage only; a bypassed word never touches the array.
    assign deq       = ~empty & out_rdy[i];

`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
    logic pass;
    // An empty port forwards its input word; it skips storage if taken now.
    assign pass       = empty & enq & out_rdy[i];
    assign wr         = enq & ~pass;
    assign out_val[i] = reset & (~empty | in_val[i]);
    assign out[i*nbits +: nbits] = empty ? din : mem[deq_ptr];
`else
    assign wr         = enq;
    assign out_val[i] = ~empty;
    assign out[i*nbits +: nbits] = mem[deq_ptr];
`endif

    assign count[i*cw +: cw] = cnt;

    // Pointers and occupancy; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        enq_ptr <= '0;
        deq_ptr <= '0;
        cnt     <= '0;
      end else begin
        if (wr)  enq_ptr <= enq_ptr + pw'(1);
        if (deq) deq_ptr <= deq_ptr + pw'(1);
        case ({wr, deq})
          2'b10:   cnt <= cnt + cw'(1);
          2'b01:   cnt <= cnt - cw'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Storage array; not reset.
    always_ff @(posedge clk) begin
      if (wr) mem[enq_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_port_array_queue.sv
module tb_port_array_queue;

  localparam int unsigned NP = 2;
  localparam int unsigned NB = 32;
  localparam int unsigned NE = 2;
  localparam int unsigned CW = $clog2(NE + 1);
`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [NB-1:0] word_t;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     in_val;
  logic [NP-1:0]     in_rdy;
  logic [NP*NB-1:0]  in_;
  logic [NP-1:0]     out_val;
  logic [NP-1:0]     out_rdy;
  logic [NP*NB-1:0]  out;
  logic [NP*CW-1:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model: one plain queue of words per port.
  word_t mq [NP][$];

  port_array_queue #(.nports(NP), .nbits(NB), .nentries(NE)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_(in_),
    .out_val(out_val), .out_rdy(out_rdy), .out(out), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input word_t d);
    in_val[p] = v;
    in_[p*NB +: NB] = d;
  endtask

  // Check every port against the model, advance one clock, update the model.
  task automatic tick();
    bit e [NP];
    bit d [NP];
    int c [NP];
    #1;
    for (int p = 0; p < NP; p++) begin
      bit rdy, val;
      c[p] = mq[p].size();
      rdy  = (c[p] != NE);
      val  = (c[p] != 0) || (BYP && in_val[p]);
      chk($sformatf("in_rdy[%0d]", p), 64'(in_rdy[p]), 64'(rdy));
      chk($sformatf("out_val[%0d]", p), 64'(out_val[p]), 64'(val));
      chk($sformatf("count[%0d]", p), 64'(count[p*CW +: CW]), 64'(c[p]));
      if (val)
        chk($sformatf("out[%0d]", p), 64'(out[p*NB +: NB]),
            64'((c[p] != 0) ? mq[p][0] : in_[p*NB +: NB]));
      e[p] = in_val[p] && rdy;
      d[p] = val && out_rdy[p];
    end
    @(posedge clk);
    for (int p = 0; p < NP; p++) begin
      if (!(BYP && c[p] == 0 && e[p] && d[p])) begin
        if (d[p]) void'(mq[p].pop_front());
        if (e[p]) mq[p].push_back(in_[p*NB +: NB]);
      end
    end
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = '0;
    out_rdy = '0;
    in_     = '0;

    // Reset held for three cycles.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_out_val", 64'(out_val), 64'(0));
      chk("rst_in_rdy", 64'(in_rdy), 64'(0));
    end
    reset = 1'b1;
    #1;
    chk("post_rst_in_rdy", 64'(in_rdy), 64'(2'b11));
    chk("post_rst_count", 64'(count), 64'(0));

    // Single word on port 0 with no consumer.
    drive(0, 1'b1, 32'hDEAD_BEEF);
    tick();
    drive(0, 1'b0, 32'h0);
    chk("single_val0", 64'(out_val[0]), 64'(1));
    chk("single_data0", 64'(out[31:0]), 64'(32'hDEAD_BEEF));
    chk("single_count0", 64'(count[0 +: CW]), 64'(1));
    chk("single_val1", 64'(out_val[1]), 64'(0));

    // Concurrent enqueue/dequeue at count 1; pointers wrap several times.
    out_rdy[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'b1, word_t'(32'h55 + k));
      tick();
      chk("conc_count0", 64'(count[0 +: CW]), 64'(1));
    end
    drive(0, 1'b0, 32'h0);
    tick();
    out_rdy[0] = 1'b0;

    // Fill and drain port 1.
    drive(1, 1'b1, 32'h1);
    tick();
    drive(1, 1'b1, 32'h2);
    tick();
    drive(1, 1'b0, 32'h0);
    chk("full_in_rdy1", 64'(in_rdy[1]), 64'(0));
    chk("full_count1", 64'(count[CW +: CW]), 64'(2));
    out_rdy[1] = 1'b1;
    chk("drain_first", 64'(out[NB +: NB]), 64'(1));
    tick();
    chk("drain_second", 64'(out[NB +: NB]), 64'(2));
    tick();
    chk("drain_empty", 64'(out_val[1]), 64'(0));
    out_rdy[1] = 1'b0;

    // Port 0 full and stalled while port 1 streams eight words.
    drive(0, 1'b1, 32'hA0);
    tick();
    drive(0, 1'b1, 32'hA1);
    tick();
    drive(0, 1'b0, 32'h0);
    out_rdy[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1'b1, word_t'(32'h100 + k));
      tick();
      chk("indep_count0", 64'(count[0 +: CW]), 64'(2));
      chk("indep_head0", 64'(out[0 +: NB]), 64'(32'hA0));
    end
    drive(1, 1'b0, 32'h0);
    tick();
    out_rdy[1] = 1'b0;

    // Asynchronous reset mid-cycle with port 0 holding two words.
    chk("pre_rst_count0", 64'(count[0 +: CW]), 64'(2));
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_count0", 64'(count[0 +: CW]), 64'(0));
    chk("midrst_out_val", 64'(out_val), 64'(0));
    chk("midrst_in_rdy", 64'(in_rdy), 64'(0));
    for (int p = 0; p < NP; p++) mq[p].delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_rdy = 2'b11;
    tick();
    chk("after_rst_out_val", 64'(out_val), 64'(0));
    out_rdy = '0;

`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
    // Zero-latency pass-through on an empty port.
    drive(0, 1'b1, 32'hA5);
    out_rdy[0] = 1'b1;
    #1;
    chk("byp_val0", 64'(out_val[0]), 64'(1));
    chk("byp_data0", 64'(out[0 +: NB]), 64'(32'hA5));
    tick();
    chk("byp_count0", 64'(count[0 +: CW]), 64'(0));
    drive(0, 1'b0, 32'h0);
    out_rdy = '0;
`endif

    // Random traffic on both ports against the model.
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < NP; p++) begin
        drive(p, 1'($urandom_range(0, 1)), word_t'($urandom));
        out_rdy[p] = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
